// File: rtl/lives_hud_pkg.sv
// Shared constants and types for the lives HUD: state encoding, transparency key
// and the 16x16 heart bitmap (row 0 at the top, column 0 = MSB of each row word).
package lives_hud_pkg;

    localparam int         MAX_LIVES   = 3;
    localparam logic [7:0] TRANSPARENT = 8'hFF;

    typedef enum logic [1:0] {IDLE, BLINK, GAME_OVER} hud_state_t;

    localparam logic [0:15][15:0] HEART_MASK = {
        16'h0000, 16'h3C3C, 16'h7E7E, 16'hFFFF,
        16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
        16'h7FFE, 16'h3FFC, 16'h1FF8, 16'h0FF0,
        16'h07E0, 16'h03C0, 16'h0180, 16'h0000
    };

endpackage

// File: rtl/lives_hud_bitmap_heart_mask_rom.sv
// Combinational heart bitmap lookup: 4-bit row/column in, one mask bit out.
module heart_mask_rom
    import lives_hud_pkg::*;
(
    input  logic [3:0] row_i,
    input  logic [3:0] col_i,
    output logic       bit_o
);

    always_comb begin
        bit_o = HEART_MASK[row_i][4'd15 - col_i];
    end

endmodule

// File: rtl/lives_hud_bitmap.sv
// HUD layer drawing up to three hearts from the lives count, blinking the most
// recently lost heart and holding game_over once the last life is gone.
module lives_hud_bitmap
    import lives_hud_pkg::*;
#(
    parameter int         TOP_LEFT_X   = 16,
    parameter int         TOP_LEFT_Y   = 8,
    parameter int         HEART_SCALE  = 2,
    parameter int         HEART_GAP    = 8,
    parameter int         BLINK_FRAMES = 60,
    parameter int         BLINK_PERIOD = 8,
    parameter logic [7:0] HEART_COLOR  = 8'hE0
)
(
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic [1:0]  lives,
    output logic        drawingRequest,
    output logic [7:0]  RGBout,
    output logic        game_over
);

    localparam int SLOT_PX = 16 * HEART_SCALE;
    localparam int FRAME_W = $clog2(BLINK_FRAMES + 1);

    hud_state_t         state_q, state_d;
    logic [1:0]         lives_prev_q;
    logic [1:0]         blink_idx_q, blink_idx_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               draw_q, draw_d;
    logic [7:0]         rgb_q, rgb_d;
    logic               game_over_q, game_over_d;

    logic               loss, gain, frame_end, blink_visible;
    logic [FRAME_W-1:0] blink_phase;
    logic [11:0]        px, py, dy;
    logic [3:0]         row;
    logic               row_hit;
    logic [MAX_LIVES-1:0] slot_hit, slot_en, slot_bit;

    assign loss      = (lives < lives_prev_q);
    assign gain      = (lives > lives_prev_q);
    assign frame_end = startOfFrame && (frame_cnt_q == FRAME_W'(BLINK_FRAMES - 1));

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q      <= IDLE;
            lives_prev_q <= 2'(MAX_LIVES);
            blink_idx_q  <= 2'd0;
            frame_cnt_q  <= '0;
            draw_q       <= 1'b0;
            rgb_q        <= TRANSPARENT;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_prev_q <= lives;
            blink_idx_q  <= blink_idx_d;
            frame_cnt_q  <= frame_cnt_d;
            draw_q       <= draw_d;
            rgb_q        <= rgb_d;
            game_over_q  <= game_over_d;
        end
    end

    // A fresh loss always wins, even over a frame end in the same cycle.
    always_comb begin
        state_d     = state_q;
        blink_idx_d = blink_idx_q;
        frame_cnt_d = frame_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (loss) begin
                    state_d     = BLINK;
                    blink_idx_d = lives_prev_q - 2'd1;
                    frame_cnt_d = '0;
                end
            end
            BLINK: begin
                if (loss) begin
                    blink_idx_d = lives_prev_q - 2'd1;
                    frame_cnt_d = '0;
                end else if (gain) begin
                    state_d = IDLE;
                end else if (frame_end) begin
                    state_d = (lives == 2'd0) ? GAME_OVER : IDLE;
                end else if (startOfFrame) begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end
            GAME_OVER: begin
                if (gain) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign px          = {1'b0, pixelX};
    assign py          = {1'b0, pixelY};
    assign dy          = py - 12'(TOP_LEFT_Y);
    assign row         = 4'(dy / 12'(HEART_SCALE));
    assign row_hit     = (py >= 12'(TOP_LEFT_Y)) && (py < 12'(TOP_LEFT_Y + SLOT_PX));
    assign blink_phase = frame_cnt_q / FRAME_W'(BLINK_PERIOD);
    assign blink_visible = (state_q == BLINK) && !blink_phase[0];

    generate
        for (genvar gi = 0; gi < MAX_LIVES; gi++) begin : g_slot
            localparam logic [11:0] X0 = 12'(TOP_LEFT_X + gi * (SLOT_PX + HEART_GAP));
            logic [11:0] dx;
            logic [3:0]  col;

            assign dx           = px - X0;
            assign col          = 4'(dx / 12'(HEART_SCALE));
            assign slot_hit[gi] = row_hit && (px >= X0) && (px < X0 + 12'(SLOT_PX));
            assign slot_en[gi]  = (2'(gi) < lives) ||
                                  (blink_visible && (blink_idx_q == 2'(gi)));

            heart_mask_rom u_rom (
                .row_i (row),
                .col_i (col),
                .bit_o (slot_bit[gi])
            );
        end
    endgenerate

    always_comb begin
        draw_d      = |(slot_hit & slot_en & slot_bit);
        rgb_d       = draw_d ? HEART_COLOR : TRANSPARENT;
        game_over_d = (state_d == GAME_OVER);
    end

    assign drawingRequest = draw_q;
    assign RGBout         = rgb_q;
    assign game_over      = game_over_q;

endmodule

// File: tb/tb_lives_hud_bitmap.sv
// Scoreboard bench for lives_hud_bitmap: a driver pushes expected pixel/game_over
// values from an event-level model, a monitor pops and compares one cycle later.
module tb_lives_hud_bitmap;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic [10:0] pixelX = '0;
    logic [10:0] pixelY = '0;
    logic [1:0]  lives = 2'd3;
    logic        drawingRequest;
    logic [7:0]  RGBout;
    logic        game_over;

    always #5 clk = ~clk;

    lives_hud_bitmap dut (
        .clk            (clk),
        .resetN         (resetN),
        .startOfFrame   (startOfFrame),
        .pixelX         (pixelX),
        .pixelY         (pixelY),
        .lives          (lives),
        .drawingRequest (drawingRequest),
        .RGBout         (RGBout),
        .game_over      (game_over)
    );

    typedef struct {
        bit         draw;
        logic [7:0] rgb;
        bit         go;
        int         x;
        int         y;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    bit [15:0] heart_rows [16];

    // Reference state: which slot is blinking (-1 none), frames since loss, game over.
    int m_prev, m_blink, m_frames;
    bit m_over;

    function automatic bit ref_pixel(int x, int y, int lv);
        for (int i = 0; i < 3; i++) begin
            int x0 = 16 + i * 40;
            if (x >= x0 && x < x0 + 32 && y >= 8 && y < 40) begin
                bit vis = (i < lv) || (i == m_blink && ((m_frames / 8) % 2 == 0));
                if (vis && heart_rows[(y - 8) / 2][15 - (x - x0) / 2]) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic step(int x, int y, int lv, bit sof, bit rst);
        exp_t e;
        pixelX       = 11'(x);
        pixelY       = 11'(y);
        lives        = 2'(lv);
        startOfFrame = sof;
        resetN       = ~rst;
        e.x = x;
        e.y = y;
        if (rst) begin
            m_prev = 3; m_blink = -1; m_frames = 0; m_over = 1'b0;
            e.draw = 1'b0;
            e.rgb  = 8'hFF;
            e.go   = 1'b0;
        end else begin
            e.draw = ref_pixel(x, y, lv);
            e.rgb  = e.draw ? 8'hE0 : 8'hFF;
            if (lv < m_prev) begin
                m_blink  = m_prev - 1;
                m_frames = 0;
            end else if (lv > m_prev) begin
                m_blink = -1;
                m_over  = 1'b0;
            end else if (m_blink >= 0 && sof) begin
                m_frames++;
                if (m_frames == 60) begin
                    m_blink = -1;
                    m_over  = (lv == 0);
                end
            end
            m_prev = lv;
            e.go   = m_over;
        end
        sb.push_back(e);
        @(negedge clk);
    endtask

    function automatic int rx();
        return ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 140)) : int'($urandom_range(0, 2047));
    endfunction

    function automatic int ry();
        return ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 48)) : int'($urandom_range(0, 2047));
    endfunction

    task automatic frames(int lv, int n);
        repeat (n) begin
            step(rx(), ry(), lv, 1'b1, 1'b0);
            step(32, 24, lv, 1'b0, 1'b0);
            step(72, 24, lv, 1'b0, 1'b0);
            step(104, 24, lv, 1'b0, 1'b0);
            step(rx(), ry(), lv, 1'b0, 1'b0);
        end
    endtask

    task automatic boundary(int lv);
        for (int i = 0; i < 3; i++) begin
            int x0 = 16 + i * 40;
            step(x0 - 1, 14, lv, 1'b0, 1'b0);
            step(x0, 14, lv, 1'b0, 1'b0);
            step(x0 + 31, 14, lv, 1'b0, 1'b0);
            step(x0 + 32, 14, lv, 1'b0, 1'b0);
        end
        step(32, 7, lv, 1'b0, 1'b0);
        step(32, 8, lv, 1'b0, 1'b0);
        step(32, 39, lv, 1'b0, 1'b0);
        step(32, 40, lv, 1'b0, 1'b0);
    endtask

    task automatic chk(string name, logic [7:0] act, logic [7:0] req, int x, int y);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at (%0d,%0d): got %0h, expected %0h", name, x, y, act, req);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("drawingRequest", 8'(drawingRequest), 8'(mon_e.draw), mon_e.x, mon_e.y);
            chk("RGBout", RGBout, mon_e.rgb, mon_e.x, mon_e.y);
            chk("game_over", 8'(game_over), 8'(mon_e.go), mon_e.x, mon_e.y);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lv;
        heart_rows = '{16'h0000, 16'h3C3C, 16'h7E7E, 16'hFFFF,
                       16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                       16'h7FFE, 16'h3FFC, 16'h1FF8, 16'h0FF0,
                       16'h07E0, 16'h03C0, 16'h0180, 16'h0000};
        m_prev = 3; m_blink = -1; m_frames = 0; m_over = 1'b0;

        @(negedge clk);
        repeat (3) step(0, 0, 3, 1'b0, 1'b1);
        step(32, 24, 3, 1'b0, 1'b0);
        step(0, 0, 3, 1'b0, 1'b0);
        boundary(3);
        frames(3, 2);
        $display("[TB] reset and steady three hearts");

        frames(2, 62);
        $display("[TB] loss 3->2 blink of slot 2");

        frames(0, 62);
        frames(1, 2);
        $display("[TB] loss 2->0, game over, recovery to 1");

        frames(3, 2);
        frames(2, 30);
        frames(1, 62);
        $display("[TB] second loss mid-blink restarts animation");

        frames(3, 2);
        frames(2, 10);
        frames(3, 3);
        $display("[TB] gain during blink drops animation");

        frames(2, 20);
        repeat (2) step(rx(), ry(), 3, 1'b0, 1'b1);
        frames(3, 3);
        $display("[TB] reset mid-blink");

        lv = 3;
        repeat (400) begin
            if ($urandom_range(0, 15) == 0) lv = int'($urandom_range(0, 3));
            step(rx(), ry(), lv, ($urandom_range(0, 4) == 0), 1'b0);
        end
        $display("[TB] randomized lives/pixel traffic");

        repeat (3) @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
